rdiv_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the restoring-division datapath.
- Time-multiplexes a single (DW+1)-bit subtract/restore stage over QW cycles instead of instantiating QW unrolled stages.
- Produces quotient and remainder bit-identical to the unrolled array: same operand widths, same (DW+1)-bit trial-subtract window.
- Sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides.

---
 rtl/rdiv_seq_ctrl_if.sv | 43 ++++
 rtl/rdiv_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_rdiv_seq_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/rdiv_seq_ctrl_if.sv
// Operand/result handshake bundle for rdiv_seq_ctrl.
// The master side is the operand producer and result consumer; the slave side is the sequencer.
interface rdiv_seq_ctrl_if #(
    parameter int unsigned QW = 4,
    parameter int unsigned DW = 3
);
    logic                 in_valid;
    logic                 in_ready;
    logic [QW+DW-2:0]     R_0;
    logic [DW-1:0]        D;
    logic                 out_valid;
    logic                 out_ready;
    logic [QW-1:0]        Q;
    logic [DW:0]          R_n1;
    logic                 ovf;
    logic                 busy;

    modport master (
        output in_valid,
        output R_0,
        output D,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Q,
        input  R_n1,
        input  ovf,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  R_0,
        input  D,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Q,
        output R_n1,
        output ovf,
        output busy
    );
endinterface

// File: rtl/rdiv_seq_ctrl.sv
// Sequential restoring divider: one (DW+1)-bit trial-subtract stage reused over QW cycles.
// Optional macro RDIV_DIVZERO_BYPASS_EN: a zero divisor skips ITER and completes in one cycle.
module rdiv_seq_ctrl #(
    parameter int unsigned QW = 4,
    parameter int unsigned DW = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    rdiv_seq_ctrl_if.slave bus
);
    localparam int unsigned WW = QW + DW;
    localparam int unsigned KW = (QW > 1) ? $clog2(QW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(QW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   w_q, w_d;
    logic [KW-1:0]   k_q, k_d;
    logic [DW-1:0]   dv_q, dv_d;
    logic [QW-1:0]   q_q, q_d;
    logic [DW:0]     r_q, r_d;
    logic            ovf_q, ovf_d;
    logic            hold_q, hold_d;

    logic [DW:0]     win;
    logic [DW+1:0]   sum;
    logic [DW:0]     diff;
    logic            qbit;
    logic [WW-1:0]   lim_in;
    logic            ovf_in;
    logic            accept;

    // The carry out of the window subtract is the quotient bit, so D==0 always yields 1s.
    assign win  = w_q[k_q +: DW+1];
    assign sum  = {1'b0, win} + {2'b01, ~dv_q} + (DW+2)'(1);
    assign diff = sum[DW:0];
    assign qbit = sum[DW+1];

    assign lim_in = {bus.D, {QW{1'b0}}};
    assign ovf_in = (bus.D == '0) || ({1'b0, bus.R_0} >= lim_in);

    assign bus.in_ready  = (state_q == S_IDLE) && !hold_q;
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.Q         = q_q;
    assign bus.R_n1      = r_q;
    assign bus.ovf       = ovf_q;

    assign accept = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        k_d     = k_q;
        dv_d    = dv_q;
        q_d     = q_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        hold_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    w_d     = {1'b0, bus.R_0};
                    k_d     = K_LAST;
                    dv_d    = bus.D;
                    q_d     = '0;
                    ovf_d   = ovf_in;
                    state_d = S_ITER;
`ifdef RDIV_DIVZERO_BYPASS_EN
                    if (bus.D == '0) begin
                        q_d     = '1;
                        r_d     = bus.R_0[DW:0];
                        state_d = S_DONE;
                    end
`endif
                end
            end

            S_ITER: begin
                q_d[k_q] = qbit;
                if (qbit) begin
                    w_d[k_q +: DW+1] = diff;
                end
                if (k_q == '0) begin
                    r_d     = qbit ? diff : win;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q - KW'(1);
                end
            end

            S_DONE: begin
                // One idle cycle after the result handshake before the next accept.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    hold_d  = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            k_q     <= '0;
            dv_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
            hold_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            k_q     <= k_d;
            dv_q    <= dv_d;
            q_q     <= q_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
            hold_q  <= hold_d;
        end
    end

    a_result_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=>
            (bus.out_valid && $stable(bus.Q) && $stable(bus.R_n1) && $stable(bus.ovf)));

    a_ready_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_ready && bus.busy));
endmodule

// File: tb/tb_rdiv_seq_ctrl.sv
// Randomized self-checking bench for rdiv_seq_ctrl against an integer restoring-division model.
// Honours RDIV_DIVZERO_BYPASS_EN for the expected zero-divisor latency.
module tb_rdiv_seq_ctrl;
    localparam int QW = 4;
    localparam int DW = 3;
    localparam int NW = QW + DW - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    rdiv_seq_ctrl_if #(.QW(QW), .DW(DW)) bus ();

    rdiv_seq_ctrl #(.QW(QW), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Quotient bit i is set when the (DW+1)-bit window of the partial dividend at i covers D.
    function automatic void model(input int r0, input int d, output int q, output int r,
                                  output bit o);
        int w;
        int win;
        w = r0;
        q = 0;
        for (int i = QW - 1; i >= 0; i--) begin
            win = (w >> i) % (1 << (DW + 1));
            if (win >= d) begin
                q = q | (1 << i);
                w = w - (d << i);
            end
        end
        r = w % (1 << (DW + 1));
        o = (d == 0) || (r0 >= (d << QW));
    endfunction

    function automatic int exp_latency(input int d);
`ifdef RDIV_DIVZERO_BYPASS_EN
        if (d == 0) return 1;
`endif
        return QW + 1;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        step();
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.Q !== '0) begin failures++; $display("FAIL reset_Q got=%0d exp=0", bus.Q); end
        checks++; if (bus.R_n1 !== '0) begin failures++; $display("FAIL reset_R got=%0d exp=0", bus.R_n1); end
        checks++; if (bus.ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic run_op(input int r0, input int d, input int ready_delay, input string tag);
        int eq, er, lat, guard;
        bit eo;
        model(r0, d, eq, er, eo);
        guard = 0;
        while (!bus.in_ready && guard < 20) begin step(); guard++; end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s wait_in_ready got=%b exp=1", tag, bus.in_ready); end
        bus.R_0 = NW'(r0);
        bus.D = DW'(d);
        bus.in_valid = 1'b1;
        bus.out_ready = (ready_delay == 0);
        step();
        bus.in_valid = 1'b0;
        bus.R_0 = NW'($urandom);
        bus.D = DW'($urandom);
        lat = 1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL %s in_ready_drop got=%b exp=0", tag, bus.in_ready); end
        while (!bus.out_valid && lat < 20) begin step(); lat++; end
        checks++; if (lat != exp_latency(d)) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", tag, lat, exp_latency(d)); end
        checks++; if (bus.Q !== QW'(eq)) begin failures++; $display("FAIL %s Q got=%0d exp=%0d (R_0=%0d D=%0d)", tag, bus.Q, eq, r0, d); end
        checks++; if (bus.R_n1 !== (DW+1)'(er)) begin failures++; $display("FAIL %s R_n1 got=%0d exp=%0d (R_0=%0d D=%0d)", tag, bus.R_n1, er, r0, d); end
        checks++; if (bus.ovf !== eo) begin failures++; $display("FAIL %s ovf got=%b exp=%b (R_0=%0d D=%0d)", tag, bus.ovf, eo, r0, d); end
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL %s busy_done got=%b exp=1", tag, bus.busy); end
        for (int i = 0; i < ready_delay; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.Q !== QW'(eq)) begin failures++; $display("FAIL %s stall_hold out_valid=%b Q=%0d exp 1/%0d", tag, bus.out_valid, bus.Q, eq); end
        end
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s out_valid_clear got=%b exp=0", tag, bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL %s holdoff_in_ready got=%b exp=0", tag, bus.in_ready); end
        step();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready_return got=%b exp=1", tag, bus.in_ready); end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_directed;
        int r0s[5] = '{45, 63, 5, 20, 42};
        int ds[5]  = '{6, 7, 7, 1, 0};
        for (int i = 0; i < 5; i++) run_op(r0s[i], ds[i], 0, "directed");
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++)
            run_op(int'($urandom_range(0, (1 << NW) - 1)), int'($urandom_range(0, (1 << DW) - 1)),
                   int'($urandom_range(0, 3)), "random");
    endtask

    task automatic test_backpressure;
        int guard;
        run_op(45, 6, 0, "bp_warmup");
        bus.R_0 = NW'(45);
        bus.D = DW'(6);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin step(); guard++; end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'($urandom);
            bus.R_0 = NW'($urandom);
            bus.D = DW'($urandom);
            step();
            checks++; if (bus.out_valid !== 1'b1 || bus.Q !== QW'(7) || bus.R_n1 !== (DW+1)'(3))
                begin failures++; $display("FAIL bp_hold out_valid=%b Q=%0d R=%0d exp 1/7/3", bus.out_valid, bus.Q, bus.R_n1); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        step();
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_release got=%b exp=0", bus.out_valid); end
        bus.out_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid;
        bus.R_0 = NW'(45);
        bus.D = DW'(6);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0)
            begin failures++; $display("FAIL midreset_ctrl in_ready=%b out_valid=%b busy=%b exp 1/0/0", bus.in_ready, bus.out_valid, bus.busy); end
        checks++; if (bus.Q !== '0 || bus.R_n1 !== '0 || bus.ovf !== 1'b0)
            begin failures++; $display("FAIL midreset_data Q=%0d R=%0d ovf=%b exp 0/0/0", bus.Q, bus.R_n1, bus.ovf); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midreset_no_output cycle=%0d got=%b exp=0", i, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
        run_op(45, 6, 0, "after_reset");
    endtask

    task automatic test_back_to_back;
        int qq[$], rq[$];
        bit oq[$];
        int sent, got, eq, er;
        bit eo, accepted;
        sent = 0;
        got = 0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.R_0 = NW'($urandom);
        bus.D = DW'($urandom);
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            if (bus.out_valid) begin
                checks++;
                if (qq.size() == 0) begin
                    failures++; $display("FAIL b2b_unexpected_result Q=%0d", bus.Q);
                end else begin
                    eq = qq.pop_front(); er = rq.pop_front(); eo = oq.pop_front();
                    if (bus.Q !== QW'(eq) || bus.R_n1 !== (DW+1)'(er) || bus.ovf !== eo) begin
                        failures++;
                        $display("FAIL b2b_result got Q=%0d R=%0d ovf=%b exp Q=%0d R=%0d ovf=%b", bus.Q, bus.R_n1, bus.ovf, eq, er, eo);
                    end
                end
                got++;
            end
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) begin
                model(int'(bus.R_0), int'(bus.D), eq, er, eo);
                qq.push_back(eq); rq.push_back(er); oq.push_back(eo);
                sent++;
            end
            step();
            if (accepted) begin
                bus.R_0 = NW'($urandom);
                bus.D = DW'($urandom);
                if (sent == 6) bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (got != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", got); end
        step();
        step();
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.R_0 = '0;
        bus.D = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
